// File: rtl/iter_alu.sv
// Small ALU: single-cycle logic/arith ops plus WIDTH-cycle shift-add multiply
// and restoring divide, with a valid/ready handshake on both sides.
//
// state  | meaning
// IDLE   | ready for a request
// CALC   | iterating multiply or divide, one step per cycle
// DONE   | result held until the consumer takes it
module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             less,
    output logic             zero,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t               state_q;
    logic [2:0]           iop_q;
    logic [WIDTH-1:0]     a_q, m_q, result_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 neg_q, negr_q, div0_q, less_q, zero_q;

    logic [SHW-1:0]       sh;
    logic [WIDTH-1:0]     sc_res;
    logic                 sc_less;

    assign sh = b[SHW-1:0];

    always_comb begin
        sc_res  = '0;
        sc_less = 1'b0;
        case (op)
            5'b00000: sc_res = a + b;
            5'b00001: sc_res = a - b;
            5'b00010: sc_res = a << sh;
            5'b00011: sc_res = a >> sh;
            5'b00100: sc_res = WIDTH'($signed(a) >>> sh);
            5'b00101: begin
                sc_less = $signed(a) < $signed(b);
                sc_res  = WIDTH'(sc_less);
            end
            5'b00110: begin
                sc_less = a < b;
                sc_res  = WIDTH'(sc_less);
            end
            5'b00111: sc_res = a ^ b;
            5'b01000: sc_res = a | b;
            5'b01001: sc_res = a & b;
            5'b01010: sc_res = b;
            default:  sc_res = '0;
        endcase
    end

    // Operand magnitudes and sign-correction flags captured at acceptance
    logic             is_iter, is_mul, sgn_a, sgn_b, neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign is_iter = op[4] & ~op[3];
    assign is_mul  = ~op[2];
    assign sgn_a   = (op[2:0] == 3'b001) | (op[2:0] == 3'b010) |
                     (op[2:0] == 3'b100) | (op[2:0] == 3'b110);
    assign sgn_b   = (op[2:0] == 3'b001) | (op[2:0] == 3'b100) |
                     (op[2:0] == 3'b110);
    assign neg_a   = sgn_a & a[WIDTH-1];
    assign neg_b   = sgn_b & b[WIDTH-1];
    assign mag_a   = neg_a ? -a : a;
    assign mag_b   = neg_b ? -b : b;

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [WIDTH:0]       mul_sum, rem_sh;
    logic [WIDTH-1:0]     rem_diff;
    logic                 rem_ge;
    logic [2*WIDTH-1:0]   acc_nxt, prod;
    logic [WIDTH-1:0]     quo, rmd, fin;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_ge   = rem_sh >= {1'b0, m_q};
    assign rem_diff = rem_sh[WIDTH-1:0] - m_q;

    always_comb begin
        acc_nxt = acc_q;
        if (!iop_q[2])
            acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
        else if (rem_ge)
            acc_nxt = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
        else
            acc_nxt = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    assign prod = neg_q ? -acc_nxt : acc_nxt;
    assign quo  = acc_nxt[WIDTH-1:0];
    assign rmd  = acc_nxt[2*WIDTH-1:WIDTH];

    always_comb begin
        fin = '0;
        case (iop_q)
            3'b000:                 fin = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fin = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fin = div0_q ? '1 : (neg_q ? -quo : quo);
            default:                fin = div0_q ? a_q : (negr_q ? -rmd : rmd);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            iop_q    <= '0;
            a_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            div0_q   <= 1'b0;
            result_q <= '0;
            less_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    a_q    <= a;
                    iop_q  <= op[2:0];
                    div0_q <= (b == '0);
                    if (is_iter) begin
                        acc_q   <= {{WIDTH{1'b0}}, (is_mul ? mag_b : mag_a)};
                        m_q     <= is_mul ? mag_a : mag_b;
                        neg_q   <= neg_a ^ neg_b;
                        negr_q  <= neg_a;
                        cnt_q   <= CW'(WIDTH);
                        state_q <= S_CALC;
                    end else begin
                        result_q <= sc_res;
                        less_q   <= sc_less;
                        zero_q   <= (sc_res == '0);
                        state_q  <= S_DONE;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        result_q <= fin;
                        less_q   <= 1'b0;
                        zero_q   <= (fin == '0);
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: if (out_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_CALC);
    assign result    = result_q;
    assign less      = less_q;
    assign zero      = zero_q;
endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, datapath width in bits; power of two, at least 8; SHW = log2(WIDTH).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; clk and rst_n are the clock and reset ports.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 op  input  5  operation code.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B; shift amount is b[SHW-1:0].
REQ-010 out_valid  output  1  result, less and zero are valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 less  output  1  comparison flag.
REQ-014 zero  output  1  flag set when result is all zeros.
REQ-015 busy  output  1  high in CALC state.

Function
REQ-016 Single-cycle op codes SHALL be: 00000 ADD, 00001 SUB, 00010 SLL, 00011 SRL, 00100 SRA, 00101 SLT, 00110 SLTU, 00111 XOR, 01000 OR, 01001 AND, 01010 PASSB (result = b).
REQ-017 Iterative op codes SHALL be: 10000 MUL (low half), 10001 MULH (s×s high), 10010 MULHSU (s×u high), 10011 MULHU (u×u high), 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
REQ-018 Any other op code SHALL complete as a single-cycle op with result 0.
REQ-019 The FSM SHALL have three states: IDLE, CALC and DONE; reset enters IDLE.
REQ-020 in_ready SHALL equal (state == IDLE); a request is accepted on a rising edge where in_valid and in_ready are both high.
REQ-021 On acceptance, a and b SHALL be latched; later changes to a, b and op have no effect until the next acceptance.
REQ-022 An accepted single-cycle op SHALL go IDLE->DONE with its registered result; out_valid is high after exactly 1 edge.
REQ-023 An accepted iterative op SHALL go IDLE->CALC, perform exactly WIDTH iterations (one per cycle), then go CALC->DONE; out_valid is high WIDTH+1 edges after acceptance, independent of operand values.
REQ-024 Multiply SHALL be shift-add on magnitudes with sign correction; the 2×WIDTH product is exact for all signedness variants.
REQ-025 Divide SHALL be restoring, one quotient bit per iteration, on magnitudes; quotient truncates toward zero; remainder takes the dividend's sign.
REQ-026 Divide by zero SHALL give quotient all-ones (DIV and DIVU) and remainder = a (REM and REMU), with normal latency.
REQ-027 Signed overflow (a = 1<<(WIDTH-1), b = all-ones) SHALL give DIV = a and REM = 0.
REQ-028 less SHALL be the signed (SLT) or unsigned (SLTU) a<b result for those ops, and 0 for all other ops; zero = (result == 0) for every op.
REQ-029 In DONE, out_valid SHALL be 1 and result, less and zero SHALL be held stable until an edge with out_ready high; that edge returns the FSM to IDLE.
REQ-030 There SHALL be no DONE->CALC or DONE->DONE bypass; a new request is accepted only in IDLE, giving at least one idle cycle between results.
REQ-031 in_valid SHALL be ignored in CALC and DONE; no request is queued.
REQ-032 All arithmetic SHALL wrap modulo 2^WIDTH except the high-half multiply outputs.

Reset
REQ-033 While rst_n is low, regardless of clk: state = IDLE, out_valid = 0, busy = 0, result = 0, less = 0, zero = 0; in_ready is 1 once rst_n is high.
REQ-034 Reset asserted in CALC or DONE SHALL abort the operation and discard its result; the first request after release behaves per REQ-022 and REQ-023.

Verification
REQ-035 ADD, a=0x7FFFFFFF, b=1, out_ready=1 -> result 0x80000000, zero 0, less 0, out_valid 1 edge after accept.
REQ-036 SLT, a=0xFFFFFFFF, b=1 -> result 1, less 1; SLTU with the same operands -> result 0, less 0, zero 1.
REQ-037 MULHU, a=b=0xFFFFFFFF -> result 0xFFFFFFFE at 33 edges, busy high for 32 cycles; MUL with the same operands -> 0x00000001.
REQ-038 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
REQ-039 SRA, a=0x80000000, b=0x00000024 -> result 0xF8000000 (shift 4); out_ready low for 5 cycles with in_valid high -> out_valid and result stable, in_ready 0, nothing accepted.
REQ-040 DIVU started, rst_n pulsed low at iteration 10 -> outputs at reset values immediately; next ADD 2+3 -> result 5 after 1 edge.
